// File: rtl/hsv_fader_pkg.sv
// hsv_fader shared types: channel roles, FSM states, sector role table.
// Optional brightness scaling is enabled with HSV_FADER_BRIGHTNESS_EN.
package hsv_fader_pkg;

  typedef enum logic [1:0] {
    INCREMENTING,
    DECREMENTING,
    HIGH_HOLD,
    LOW_HOLD
  } role_e;

  typedef enum logic {
    RUN,
    STOPPED
  } state_e;

  typedef struct packed {
    role_e r;
    role_e g;
    role_e b;
  } roles_t;

  function automatic roles_t sector_roles(input logic [2:0] s);
    roles_t t;
    case (s)
      3'd0: t = '{HIGH_HOLD, INCREMENTING, LOW_HOLD};
      3'd1: t = '{DECREMENTING, HIGH_HOLD, LOW_HOLD};
      3'd2: t = '{LOW_HOLD, HIGH_HOLD, INCREMENTING};
      3'd3: t = '{LOW_HOLD, DECREMENTING, HIGH_HOLD};
      3'd4: t = '{INCREMENTING, LOW_HOLD, HIGH_HOLD};
      3'd5: t = '{HIGH_HOLD, LOW_HOLD, DECREMENTING};
      default: t = '{LOW_HOLD, LOW_HOLD, LOW_HOLD};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/hsv_fader_if.sv
// hsv_fader control/status bundle.
// brightness exists only with HSV_FADER_BRIGHTNESS_EN.
interface hsv_fader_if;
  logic       en;
  logic       dir;
  logic       mode;
  logic       start;
  logic [2:0] sector;
  logic       done;
`ifdef HSV_FADER_BRIGHTNESS_EN
  logic [7:0] brightness;

  modport master (
    output en, dir, mode, start, brightness,
    input  sector, done
  );
  modport slave (
    input  en, dir, mode, start, brightness,
    output sector, done
  );
`else
  modport master (
    output en, dir, mode, start,
    input  sector, done
  );
  modport slave (
    input  en, dir, mode, start,
    output sector, done
  );
`endif
endinterface

// File: rtl/hsv_fader_pwm_channel.sv
// One PWM channel: free-running counter, duty latched per period.
// HSV_FADER_BRIGHTNESS_EN adds brightness scaling of the latched duty.
module hsv_pwm_channel #(
  parameter  int PWM_INTERVAL = 1200,
  localparam int DW = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] duty,
`ifdef HSV_FADER_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  output logic          pwm_out
);

  localparam logic [DW-1:0] LAST = DW'(PWM_INTERVAL - 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] scaled;

`ifdef HSV_FADER_BRIGHTNESS_EN
  logic [DW+8:0] prod;
  // brightness+1 keeps 255 exact: duty*256>>8
  assign prod   = (DW+9)'(duty) * (DW+9)'({1'b0, brightness} + 9'd1);
  assign scaled = DW'(prod >> 8);
`else
  assign scaled = duty;
`endif

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + DW'(1);
    duty_d = (cnt_q == LAST) ? scaled : duty_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
    end
  end

  assign pwm_out = (cnt_q < duty_q);

endmodule

// File: rtl/hsv_fader.sv
// HSV colour-wheel fader for a common-anode RGB LED.
// Define HSV_FADER_BRIGHTNESS_EN for the global brightness input.
module hsv_fader
  import hsv_fader_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int DUTY_STEP    = 12,
  parameter int STEP_CYCLES  = 24000
) (
  input  logic         clk,
  input  logic         rst,
  hsv_fader_if.slave   io,
  output logic         RGB_R,
  output logic         RGB_G,
  output logic         RGB_B
);

  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam logic [DW-1:0] PI_W = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] RMAX = DW'(PWM_INTERVAL - DUTY_STEP);
  localparam logic [DW-1:0] STEP = DW'(DUTY_STEP);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  state_e        state_q, state_d;
  logic [2:0]    sector_q, sector_d;
  logic [DW-1:0] ramp_q, ramp_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic          done_q, done_d;

  always_comb begin
    state_d    = state_q;
    sector_d   = sector_q;
    ramp_d     = ramp_q;
    step_cnt_d = step_cnt_q;
    done_d     = 1'b0;
    if (state_q == STOPPED) begin
      if (io.start || !io.mode) state_d = RUN;
    end else if (io.en) begin
      if (step_cnt_q != STEP_LAST) begin
        step_cnt_d = step_cnt_q + SW'(1);
      end else begin
        step_cnt_d = '0;
        if (!io.dir) begin
          if (ramp_q == RMAX) begin
            ramp_d   = '0;
            sector_d = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
          end else begin
            ramp_d = ramp_q + STEP;
          end
        end else begin
          if (ramp_q == '0) begin
            ramp_d   = RMAX;
            sector_d = (sector_q == 3'd0) ? 3'd5 : sector_q - 3'd1;
          end else begin
            ramp_d = ramp_q - STEP;
          end
        end
        // one-shot ends on arrival at the wheel origin
        if (io.mode && sector_d == 3'd0 && ramp_d == '0) begin
          state_d = STOPPED;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      sector_q   <= '0;
      ramp_q     <= '0;
      step_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sector_q   <= sector_d;
      ramp_q     <= ramp_d;
      step_cnt_q <= step_cnt_d;
      done_q     <= done_d;
    end
  end

  assign io.sector = sector_q;
  assign io.done   = done_q;

  function automatic logic [DW-1:0] role_duty(
    input role_e r, input logic [DW-1:0] ramp
  );
    case (r)
      INCREMENTING: return ramp;
      DECREMENTING: return PI_W - ramp;
      HIGH_HOLD:    return PI_W;
      default:      return '0;
    endcase
  endfunction

  roles_t        roles;
  logic [DW-1:0] duty_r, duty_g, duty_b;
  logic          pwm_r, pwm_g, pwm_b;

  assign roles  = sector_roles(sector_q);
  assign duty_r = role_duty(roles.r, ramp_q);
  assign duty_g = role_duty(roles.g, ramp_q);
  assign duty_b = role_duty(roles.b, ramp_q);

  hsv_pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch_r (
    .clk(clk), .rst(rst), .duty(duty_r),
`ifdef HSV_FADER_BRIGHTNESS_EN
    .brightness(io.brightness),
`endif
    .pwm_out(pwm_r)
  );

  hsv_pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch_g (
    .clk(clk), .rst(rst), .duty(duty_g),
`ifdef HSV_FADER_BRIGHTNESS_EN
    .brightness(io.brightness),
`endif
    .pwm_out(pwm_g)
  );

  hsv_pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch_b (
    .clk(clk), .rst(rst), .duty(duty_b),
`ifdef HSV_FADER_BRIGHTNESS_EN
    .brightness(io.brightness),
`endif
    .pwm_out(pwm_b)
  );

  assign RGB_R = ~pwm_r;
  assign RGB_G = ~pwm_g;
  assign RGB_B = ~pwm_b;

endmodule

// File: tb/tb_hsv_fader.sv
// hsv_fader bench: hue-wheel model compared every cycle plus directed
// literal checks. Brightness cases build only with HSV_FADER_BRIGHTNESS_EN.
module tb_hsv_fader;

  localparam int PI = 12;
  localparam int DS = 3;
  localparam int SC = 4;
  localparam int K  = PI / DS;
  localparam int N  = 6 * K;

  logic clk;
  logic rst;
  logic RGB_R, RGB_G, RGB_B;

  hsv_fader_if io ();

  hsv_fader #(
    .PWM_INTERVAL(PI),
    .DUTY_STEP(DS),
    .STEP_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io),
    .RGB_R(RGB_R),
    .RGB_G(RGB_G),
    .RGB_B(RGB_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Hue model: position is a step index h on a 24-step wheel; channel
  // level follows the standard HSV piecewise formula with offset n sixths.
  int m_h, m_timer, m_cnt;
  bit m_stop, m_done;
  int m_lat [3];

  function automatic int hue_duty(input int h, input int ch);
    int n, k, m;
    n = (ch == 0) ? 5 : (ch == 1) ? 3 : 1;
    k = (n * K + h) % N;
    m = k;
    if (4 * K - k < m) m = 4 * K - k;
    if (m < 0) m = 0;
    if (m > K) m = K;
    return PI - (PI * m) / K;
  endfunction

  function automatic int bri_val();
`ifdef HSV_FADER_BRIGHTNESS_EN
    return int'(io.brightness);
`else
    return 255;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_h = 0; m_timer = 0; m_cnt = 0;
      m_stop = 0; m_done = 0;
      for (int i = 0; i < 3; i++) m_lat[i] = 0;
    end else begin
      if (m_cnt == PI - 1)
        for (int i = 0; i < 3; i++)
          m_lat[i] = (hue_duty(m_h, i) * (bri_val() + 1)) / 256;
      m_cnt = (m_cnt + 1) % PI;
      m_done = 0;
      if (m_stop) begin
        if (io.start || !io.mode) m_stop = 0;
      end else if (io.en) begin
        m_timer++;
        if (m_timer == SC) begin
          m_timer = 0;
          m_h = io.dir ? (m_h + N - 1) % N : (m_h + 1) % N;
          if (io.mode && m_h == 0) begin
            m_stop = 1;
            m_done = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sector", int'(io.sector), m_h / K);
      check("done", int'(io.done), int'(m_done));
      check("rgb_r", int'(RGB_R), (m_cnt < m_lat[0]) ? 0 : 1);
      check("rgb_g", int'(RGB_G), (m_cnt < m_lat[1]) ? 0 : 1);
      check("rgb_b", int'(RGB_B), (m_cnt < m_lat[2]) ? 0 : 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input bit e, input bit d, input bit m);
    rst = 1'b1;
    io.en = e; io.dir = d; io.mode = m; io.start = 1'b0;
    cyc(3);
    chk_en = 1;
    rst = 1'b0;
  endtask

  int lr, lg, lb, dn, first_dn, s0, frozen, tog;
  logic prev_b;

  initial begin
    rst = 1'b1;
    io.en = 1'b0; io.dir = 1'b0; io.mode = 1'b0; io.start = 1'b0;
`ifdef HSV_FADER_BRIGHTNESS_EN
    io.brightness = 8'd255;
`endif
    cyc(1);

    // reset state, dark first period, then red full
    do_reset(0, 0, 0);
    check("rst_rgb", int'({RGB_R, RGB_G, RGB_B}), 7);
    check("rst_sector", int'(io.sector), 0);
    check("rst_done", int'(io.done), 0);
    lr = 0;
    for (int i = 0; i < PI; i++) begin
      lr += (RGB_R == 0) + (RGB_G == 0) + (RGB_B == 0);
      cyc(1);
    end
    check("dark_period", lr, 0);
    lr = 0; lg = 0; lb = 0;
    for (int i = 0; i < PI; i++) begin
      lr += int'(RGB_R == 0); lg += int'(RGB_G == 0); lb += int'(RGB_B == 0);
      cyc(1);
    end
    check("red_low", lr, 12);
    check("green_low", lg, 0);
    check("blue_low", lb, 0);

    // continuous forward walk
    do_reset(1, 0, 0);
    cyc(16);
    check("fwd_sec1", int'(io.sector), 1);
    cyc(80);
    check("fwd_wrap", int'(io.sector), 0);

    // reverse walk
    do_reset(1, 1, 0);
    cyc(4);
    check("rev_sec5", int'(io.sector), 5);
    cyc(16);
    check("rev_sec4", int'(io.sector), 4);

    // one-shot revolution
    do_reset(1, 0, 1);
    dn = 0; first_dn = -1;
    for (int i = 1; i <= 200; i++) begin
      cyc(1);
      if (io.done) begin
        dn++;
        if (first_dn < 0) first_dn = i;
      end
    end
    check("oneshot_pulses", dn, 1);
    check("oneshot_time", first_dn, 96);
    check("stopped_sector", int'(io.sector), 0);
    io.start = 1'b1;
    cyc(1);
    io.start = 1'b0;
    dn = 0;
    for (int i = 0; i < 120; i++) begin
      cyc(1);
      dn += int'(io.done);
    end
    check("restart_pulses", dn, 1);

    // freeze in sector 2, then resume from the held step count
    do_reset(1, 0, 0);
    cyc(41);
    io.en = 1'b0;
    s0 = int'(io.sector);
    check("freeze_sector", s0, 2);
    frozen = 0; tog = 0; prev_b = RGB_B;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (int'(io.sector) != s0) frozen++;
      if (RGB_B != prev_b) tog++;
      prev_b = RGB_B;
    end
    check("frozen_moves", frozen, 0);
    check("b_toggles", int'(tog > 4), 1);
    io.en = 1'b1;
    cyc(6);
    check("resume_sec2", int'(io.sector), 2);
    cyc(1);
    check("resume_sec3", int'(io.sector), 3);

`ifdef HSV_FADER_BRIGHTNESS_EN
    io.brightness = 8'd127;
    do_reset(0, 0, 0);
    cyc(PI);
    lr = 0;
    for (int i = 0; i < PI; i++) begin
      lr += int'(RGB_R == 0);
      cyc(1);
    end
    check("bri127_red", lr, 6);
    io.brightness = 8'd255;
    do_reset(0, 0, 0);
    cyc(PI);
    lr = 0;
    for (int i = 0; i < PI; i++) begin
      lr += int'(RGB_R == 0);
      cyc(1);
    end
    check("bri255_red", lr, 12);
`endif

    chk_en = 0;
    cyc(1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/hsv_fader.md
# hsv_fader

Parametrised HSV colour-wheel fader driving one common-anode RGB LED. It walks hue around six 60° sectors in configurable steps, and runs continuously or for a single revolution. Direction is selectable and the walk can be frozen. Each colour channel gets a glitch-free PWM whose duty is latched per period. It sits directly under the board top level, between `clk`/`rst` and the active-low `RGB_R`/`RGB_G`/`RGB_B` pins.

## Interface
- `PWM_INTERVAL`, 1200: PWM period in clk cycles (100 µs at 12 MHz).
- `DUTY_STEP`, 12: duty increment per hue step; `PWM_INTERVAL % DUTY_STEP == 0` required.
- `STEP_CYCLES`, 24000: clk cycles per hue step (100 steps/sector → 0.2 s/sector).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: hue advance enable; PWM runs regardless.
- `dir` in 1: 0 forward (R→G→B), 1 reverse.
- `mode` in 1: 0 continuous, 1 one-shot revolution.
- `start` in 1: one-cycle pulse, restarts a revolution from STOPPED.
- `brightness` in 8: global scale (present only with `HSV_FADER_BRIGHTNESS_EN`).
- `sector` out 3: current sector 0..5.
- `done` out 1: one-cycle pulse at end of one-shot revolution.
- `RGB_R`, `RGB_G`, `RGB_B` out 1 each: active-low LED drives.

## Operation
- Position = (`sector` 0..5, `ramp` 0..RMAX), RMAX = PWM_INTERVAL−DUTY_STEP; DW = $clog2(PWM_INTERVAL+1), so duty can equal PWM_INTERVAL.
- Step timer `step_cnt` counts only when `en`=1 and FSM=RUN; tick when `step_cnt`==STEP_CYCLES−1, then wraps to 0.
- Forward tick: ramp += DUTY_STEP; at ramp==RMAX → ramp=0, sector+1 (5→0).
- Reverse tick: ramp −= DUTY_STEP; at ramp==0 → ramp=RMAX, sector−1 (0→5).
- Channel roles per sector (R,G,B): 0 HIGH,INC,LOW; 1 DEC,HIGH,LOW; 2 LOW,HIGH,INC; 3 LOW,DEC,HIGH; 4 INC,LOW,HIGH; 5 HIGH,LOW,DEC.
- Duty: HIGH=PWM_INTERVAL, LOW=0, INC=ramp, DEC=PWM_INTERVAL−ramp.
- FSM: RUN, STOPPED. In RUN with `mode`=1, a tick that lands on (0,0) → STOPPED, and `done`=1 for the following cycle. In STOPPED, position and step_cnt are held and PWM continues. `start`=1 or `mode`=0 → RUN.
- `start` is ignored in RUN. `dir`/`mode` changes take effect at the next tick. `mode` 0→1 mid-revolution stops at the next arrival at (0,0).
- PWM per channel: `cnt` 0..PWM_INTERVAL−1 free-running. `duty_q` loads on the edge where `cnt`==PWM_INTERVAL−1. pwm_out = (`cnt` < `duty_q`); LED pin = ~pwm_out.

## Timing
- Reset values: sector=0, ramp=0, step_cnt=0, FSM=RUN, done=0, PWM cnt=0, duty_q=0 → RGB_* = 1 (off).
- First PWM period after reset release is dark. Duty for (0,0) appears at cycle PWM_INTERVAL.
- Duty latency: a position change reaches the pins at the next PWM period boundary, at most PWM_INTERVAL cycles later.
- Reset mid-operation: all state returns to reset values on the next edge. `done` is cleared.
- `rst` has priority over `start`/`en`.

## Configuration
- `HSV_FADER_BRIGHTNESS_EN` defined: `brightness` port exists. Latched duty = (duty × (brightness+1)) >> 8, so 255 gives the exact duty and 0 gives near-off.
- `HSV_FADER_BRIGHTNESS_EN` undefined: no `brightness` port, and duty is unscaled.

## Structure
- `hsv_fader_pkg`: role enum (INCREMENTING, DECREMENTING, HIGH_HOLD, LOW_HOLD), FSM state enum, and sector→role lookup function.
- Sub-module `hsv_pwm_channel` (params PWM_INTERVAL; ports clk, rst, duty, pwm_out) holds the counter, the period-latched `duty_q`, and optional scaling. It is instantiated three times.

## Test plan
Use PWM_INTERVAL=12, DUTY_STEP=3, STEP_CYCLES=4: 4 steps/sector, 16 cycles/sector, 96 cycles/revolution.
- Reset for 3 cycles → all RGB_*=1, sector=0, done=0; RGB_* stay 1 for 12 cycles after release; then RGB_R low 12/12, G and B high.
- en=1, dir=0, mode=0 → sector 0,1,2,3,4,5,0, each held 16 cycles. Latched G duty in sector 0 is in {0,3,6,9} and non-decreasing.
- dir=1 from reset → sector=5 after cycle 4, ramp=9, B duty 3. B ramps up toward 12 on later ticks; sector 4 follows 16 cycles later.
- mode=1 → done pulses once, 96 cycles after release; sector stays 0 with no further pulses. A `start` pulse gives done again 96 cycles later.
- en=0 for 50 cycles in sector 2 → sector/ramp frozen while PWM keeps toggling B. On en=1, stepping resumes from the frozen step_cnt.
- Brightness (macro defined), sector 0: brightness=127 → RGB_R low 6 of 12 cycles; brightness=255 → 12 of 12.
